csa_stream_accumulator: RTL and testbench

Multi-operand streaming accumulator built on the carry-save principle: accepts a stream of unsigned operands over a valid/ready handshake and keeps the running total in redundant form as a sum vector S and a carry vector C, with one full-adder row per operand and no carry propagation. On the last operand it resolves S + C to binary by iterating the carry-save relation until the carry vector is zero, then presents the result on a valid/ready output. It converts CSA redundant form back into a plain binary word for downstream logic.

---
 rtl/csa_stream_accumulator.sv | 111 +++++++++++
 tb/tb_csa_stream_accumulator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator: sums a group of unsigned operands in redundant (S, C) form,
// then resolves S + C to binary and hands the result off. Optional overflow flag: CSA_ACC_OVF_EN.
module csa_stream_accumulator #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf
);

   typedef enum logic [1:0] {
      ST_ACC     = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ACC_W-1:0]   r_s;
   logic [ACC_W-1:0]   r_c;
   logic [ACC_W-1:0]   r_out_data;
   logic [ACC_W-1:0]   w_d;
   logic [ACC_W-1:0]   w_maj;
   logic [ACC_W-1:0]   w_and;
   logic               w_c_zero;

   assign w_d      = ACC_W'(in_data);
   assign w_maj    = (r_s & r_c) | (r_s & w_d) | (r_c & w_d);
   assign w_and    = r_s & r_c;
   assign w_c_zero = (r_c == '0);

   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_OUT);
   assign out_data  = r_out_data;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:     if (in_valid && in_last) w_state_nxt = ST_RESOLVE;
         ST_RESOLVE: if (w_c_zero)            w_state_nxt = ST_OUT;
         ST_OUT:     if (out_ready)           w_state_nxt = ST_ACC;
         default:                             w_state_nxt = ST_ACC;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_ACC;
         r_s        <= '0;
         r_c        <= '0;
         r_out_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_ACC: begin
               if (in_valid) begin
                  r_s <= r_s ^ r_c ^ w_d;
                  r_c <= w_maj << 1;
               end
            end
            ST_RESOLVE: begin
               if (w_c_zero) begin
                  r_out_data <= r_s;
               end else begin
                  r_s <= r_s ^ r_c;
                  r_c <= w_and << 1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_s <= '0;
                  r_c <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CSA_ACC_OVF_EN
   logic r_ovf;

   // A carry leaving the MSB is exactly 2^ACC_W of lost value, so it marks a wrapped sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC:     if (in_valid && w_maj[ACC_W-1])   r_ovf <= 1'b1;
            ST_RESOLVE: if (!w_c_zero && w_and[ACC_W-1])  r_ovf <= 1'b1;
            ST_OUT:     if (out_ready)                    r_ovf <= 1'b0;
            default: ;
         endcase
      end
   end

   assign out_ovf = (r_state == ST_OUT) && r_ovf;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator: directed scenarios plus randomized groups
// checked against a plain-arithmetic sum model.
module tb_csa_stream_accumulator;

   localparam int DATA_W = 4;
   localparam int ACC_W  = 8;
`ifdef CSA_ACC_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   csa_stream_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required self-termination");
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
         n_fail++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Called one edge after the in_last handshake; returns the edge count at which out_valid is seen.
   task automatic wait_result(input string name, output int lat);
      bit busy_ready = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 30) begin
         if (in_ready !== 1'b0) busy_ready = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (in_ready !== 1'b0) busy_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         $display("FAIL %s_timeout: out_valid=%b after %0d edges, required 1", name, out_valid, lat);
         n_fail++;
      end
      n_checks++;
      if (busy_ready) begin
         $display("FAIL %s_in_ready_busy: in_ready=1 seen during RESOLVE/OUT, required 0", name);
         n_fail++;
      end
   endtask

   task automatic take_result(input string name, input logic [ACC_W-1:0] exp_data,
                              input logic exp_ovf, input int min_lat, input int max_lat,
                              input int stall);
      int lat;
      bit unstable = 1'b0;
      wait_result(name, lat);
      n_checks++;
      if (lat < min_lat || lat > max_lat) begin
         $display("FAIL %s_latency: %0d edges, required %0d..%0d", name, lat, min_lat, max_lat);
         n_fail++;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b0) unstable = 1'b1;
      end
      n_checks++;
      if (unstable) begin
         $display("FAIL %s_stall: output not held during %0d stall cycles", name, stall);
         n_fail++;
      end
      n_checks++;
      if (out_data !== exp_data) begin
         $display("FAIL %s_data: out_data=%0d required %0d", name, out_data, exp_data);
         n_fail++;
      end
      n_checks++;
      if (out_ovf !== exp_ovf) begin
         $display("FAIL %s_ovf: out_ovf=%b required %b", name, out_ovf, exp_ovf);
         n_fail++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ovf !== 1'b0) begin
         $display("FAIL %s_handoff: out_valid=%b in_ready=%b out_ovf=%b required 0 1 0",
                  name, out_valid, in_ready, out_ovf);
         n_fail++;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_ovf !== 1'b0) begin
         $display("FAIL %s: out_valid=%b in_ready=%b out_data=%0d out_ovf=%b required 0 1 0 0",
                  name, out_valid, in_ready, out_data, out_ovf);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset_idle");
   endtask

   task automatic test_three_fifteen();
      send(4'd15, 1'b0);
      send(4'd15, 1'b0);
      send(4'd15, 1'b1);
      take_result("three_15", 8'd45, 1'b0, 4, 4, 0);
   endtask

   task automatic test_single();
      send(4'd9, 1'b1);
      take_result("single_9", 8'd9, 1'b0, 2, 2, 0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 18; i++) send(4'd15, (i == 17));
      take_result("overflow_270", 8'd14, OVF_EN, 2, ACC_W + 2, 0);
   endtask

   task automatic test_stall();
      int lat;
      bit bad = 1'b0;
      send(4'd5, 1'b0);
      send(4'd6, 1'b1);
      wait_result("stall", lat);
      in_valid = 1'b1;
      in_data  = 4'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== 8'd11 || in_ready !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         $display("FAIL stall_hold: out_valid=%b out_data=%0d in_ready=%b required 1 11 0",
                  out_valid, out_data, in_ready);
         n_fail++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      send(4'd7, 1'b0);
      send(4'd3, 1'b1);
      take_result("after_stall", 8'd10, 1'b0, 2, ACC_W + 2, 0);
   endtask

   task automatic test_reset_mid_resolve();
      send(4'd15, 1'b0);
      send(4'd15, 1'b0);
      send(4'd15, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("mid_resolve_reset");
      send(4'd2, 1'b0);
      send(4'd3, 1'b1);
      take_result("post_reset", 8'd5, 1'b0, 2, ACC_W + 2, 0);
   endtask

   task automatic test_back_to_back();
      int lat;
      send(4'd1, 1'b0);
      send(4'd2, 1'b1);
      wait_result("b2b_first", lat);
      n_checks++;
      if (out_data !== 8'd3) begin
         $display("FAIL b2b_first_data: out_data=%0d required 3", out_data);
         n_fail++;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'd4;
      in_last   = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL b2b_turnaround: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
         n_fail++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      take_result("b2b_second", 8'd4, 1'b0, 2, 2, 0);
   endtask

   task automatic test_random();
      for (int g = 0; g < 12; g++) begin
         int n   = $urandom_range(1, 24);
         int sum = 0;
         for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               in_last = 1'b1;
               repeat ($urandom_range(1, 3)) @(negedge clk);
               in_last = 1'b0;
            end
            sum += int'(d);
            send(d, (i == n - 1));
         end
         take_result($sformatf("random_g%0d", g), ACC_W'(sum % (1 << ACC_W)),
                     OVF_EN && (sum >= (1 << ACC_W)), 2, ACC_W + 2, $urandom_range(0, 4));
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_three_fifteen();
      test_single();
      test_overflow();
      test_stall();
      test_reset_mid_resolve();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
